// File: rtl/sbox_sub_unit.sv
// Time-multiplexed AES SubBytes / InvSubBytes unit: NSUB GF(2^8) inversion engines
// process a LANES-byte word in LANES/NSUB cycles behind a valid/ready handshake.
`timescale 1ns/1ps
module sbox_sub_unit #(
    parameter int LANES = 16,
    parameter int NSUB  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 busy
);

    localparam int GROUPS = LANES / NSUB;
    localparam int IDX_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [8*LANES-1:0] src;
    logic [8*LANES-1:0] res;
    logic               mode;
    logic [7:0]         eng_in  [NSUB];
    logic [7:0]         eng_out [NSUB];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and naturally maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    // One inversion per engine, shared by both directions.
    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] y;
        y = gf_inv(inv ? inv_affine(b) : b);
        return inv ? y : fwd_affine(y);
    endfunction

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int e = 0; e < NSUB; e++) begin
            eng_in[e]  = src[(int'(idx) * NSUB + e) * 8 +: 8];
            eng_out[e] = sub_byte(eng_in[e], mode);
        end
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_data = res;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: source and result are reset too, so an aborted word can never leak onto out_data.
            state     <= IDLE;
            idx       <= '0;
            src       <= '0;
            res       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (in_valid && in_ready) begin
                        src       <= in_data;
                        mode      <= in_inv;
                        idx       <= '0;
                        res       <= '0;
                        state     <= SUB;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                SUB: begin
                    for (int e = 0; e < NSUB; e++) begin
                        res[(int'(idx) * NSUB + e) * 8 +: 8] <= eng_out[e];
                    end
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_sub_unit.sv
// Self-checking bench for sbox_sub_unit: four parameterisations checked against an
// S-box table generated by the generator/affine iteration, independent of the RTL's inversion.
`timescale 1ns/1ps
module tb_sbox_sub_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   iv, ii, orr;
    logic [127:0] id [4];
    wire  [3:0]   ir, ov, bz;
    wire  [127:0] od0, od1, od2;
    wire  [31:0]  od3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    int grp      [4] = '{4, 16, 1, 2};
    int lanes_of [4] = '{16, 16, 16, 4};

    sbox_sub_unit #(.LANES(16), .NSUB(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_inv(ii[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0), .busy(bz[0]));
    sbox_sub_unit #(.LANES(16), .NSUB(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_inv(ii[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1), .busy(bz[1]));
    sbox_sub_unit #(.LANES(16), .NSUB(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_inv(ii[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2), .busy(bz[2]));
    sbox_sub_unit #(.LANES(4), .NSUB(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3][31:0]),
        .in_inv(ii[3]), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od3), .busy(bz[3]));

    function automatic logic [127:0] dout(input int k);
        case (k)
            0:       return od0;
            1:       return od1;
            2:       return od2;
            default: return {96'b0, od3};
        endcase
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Walk p over powers of the generator 3 and q over powers of 1/3, so q == 1/p.
    task automatic build_tables();
        logic [7:0] p, q, t;
        p = 8'h01;
        q = 8'h01;
        do begin
            t = {p[6:0], 1'b0};
            if (p[7]) t = t ^ 8'h1B;
            p = p ^ t;
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            fwd_tab[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        fwd_tab[0] = 8'h63;
        for (int v = 0; v < 256; v++) inv_tab[fwd_tab[v]] = 8'(v);
    endtask

    function automatic logic [127:0] ref_word(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++)
            r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered 1ns after a clock edge with unit k idle; returns result and accept-to-valid latency.
    task automatic run_word(input int k, input logic [127:0] d, input logic inv,
                            output logic [127:0] r, output int lat);
        iv[k] = 1'b1;
        id[k] = d;
        ii[k] = inv;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = dout(k);
        orr[k] = 1'b1;
        @(posedge clk); #1;
        orr[k] = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, ir[k]); end
            n_checks++;
            if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]); end
            n_checks++;
            if (bz[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b want 0", k, bz[k]); end
            n_checks++;
            if (dout(k) !== 128'h0) begin n_fail++; $display("FAIL reset_out_data[%0d] got %h want 0", k, dout(k)); end
        end
    endtask

    task automatic test_vectors(input logic inv, input logic [55:0] in_b, input logic [55:0] exp_b);
        logic [127:0] d, r;
        int lat;
        d = rand_word();
        d[55:0] = in_b;
        run_word(0, d, inv, r, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL vec_latency inv=%b got %0d want 4", inv, lat); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (r[8*i +: 8] !== exp_b[8*i +: 8]) begin
                n_fail++;
                $display("FAIL vec_byte inv=%b lane %0d got %h want %h", inv, i, r[8*i +: 8], exp_b[8*i +: 8]);
            end
        end
        n_checks++;
        if (r !== ref_word(d, inv, 16)) begin
            n_fail++;
            $display("FAIL vec_word inv=%b got %h want %h", inv, r, ref_word(d, inv, 16));
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] d, r1, r2;
        int lat;
        for (int n = 0; n < 64; n++) begin
            d = rand_word();
            run_word(0, d, 1'b0, r1, lat);
            n_checks++;
            if (r1 !== ref_word(d, 1'b0, 16)) begin
                n_fail++; $display("FAIL rt_forward #%0d got %h want %h", n, r1, ref_word(d, 1'b0, 16));
            end
            run_word(0, r1, 1'b1, r2, lat);
            n_checks++;
            if (r2 !== d) begin n_fail++; $display("FAIL rt_inverse #%0d got %h want %h", n, r2, d); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d1, d2, held;
        int lat;
        d1 = rand_word();
        d2 = rand_word();
        iv[0] = 1'b1; id[0] = d1; ii[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", lat); end
        held = dout(0);
        n_checks++;
        if (held !== ref_word(d1, 1'b0, 16)) begin
            n_fail++; $display("FAIL bp_data got %h want %h", held, ref_word(d1, 1'b0, 16));
        end
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dout(0) !== held || ov[0] !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got %h/%b want %h/1", c, dout(0), ov[0], held);
            end
            n_checks++;
            if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", c, ir[0]); end
        end
        iv[0] = 1'b1; id[0] = d2; ii[0] = 1'b1; orr[0] = 1'b1;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_follows got %b want 1", ir[0]); end
        @(posedge clk); #1;
        iv[0] = 1'b0; orr[0] = 1'b0;
        n_checks++;
        if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL bp_same_edge_accept busy/valid got %b/%b want 1/0", bz[0], ov[0]);
        end
        lat = 0;
        while (!ov[0] && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL bp_next_latency got %0d want 4", lat); end
        n_checks++;
        if (dout(0) !== ref_word(d2, 1'b1, 16)) begin
            n_fail++; $display("FAIL bp_next_data got %h want %h", dout(0), ref_word(d2, 1'b1, 16));
        end
        orr[0] = 1'b1;
        @(posedge clk); #1;
        orr[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] words [6];
        logic         modes [6];
        int i, j, cyc, last;
        logic acc;
        for (int n = 0; n < 6; n++) begin words[n] = rand_word(); modes[n] = 1'($urandom_range(0, 1)); end
        i = 0; j = 0; cyc = 0; last = 0;
        orr[0] = 1'b1;
        while (j < 6 && cyc < 200) begin
            iv[0] = (i < 6);
            id[0] = words[i < 6 ? i : 5];
            ii[0] = modes[i < 6 ? i : 5];
            #1;
            acc = iv[0] && ir[0];
            if (ov[0]) begin
                n_checks++;
                if (dout(0) !== ref_word(words[j], modes[j], 16)) begin
                    n_fail++; $display("FAIL b2b_data #%0d got %h want %h", j, dout(0), ref_word(words[j], modes[j], 16));
                end
                if (j > 0) begin
                    n_checks++;
                    if (cyc - last !== 5) begin n_fail++; $display("FAIL b2b_spacing #%0d got %0d want 5", j, cyc - last); end
                end
                last = cyc;
                j++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) i++;
        end
        n_checks++;
        if (j !== 6) begin n_fail++; $display("FAIL b2b_timeout got %0d words want 6", j); end
        iv[0] = 1'b0; orr[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mode_isolation();
        logic [127:0] d;
        int lat;
        for (int m = 0; m < 2; m++) begin
            d = rand_word();
            iv[0] = 1'b1; id[0] = d; ii[0] = 1'(m);
            @(posedge clk); #1;
            id[0] = rand_word();
            lat = 0;
            while (!ov[0] && lat < 100) begin
                ii[0] = ~ii[0];
                @(posedge clk); #1;
                lat++;
            end
            ii[0] = ~ii[0];
            @(posedge clk); #1;
            n_checks++;
            if (dout(0) !== ref_word(d, 1'(m), 16) || ov[0] !== 1'b1) begin
                n_fail++; $display("FAIL mode_iso m=%0d got %h want %h", m, dout(0), ref_word(d, 1'(m), 16));
            end
            iv[0] = 1'b0; orr[0] = 1'b1;
            @(posedge clk); #1;
            orr[0] = 1'b0;
            n_checks++;
            if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
                n_fail++; $display("FAIL mode_iso_consume m=%0d valid/busy got %b/%b want 0/0", m, ov[0], bz[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d, r;
        int lat;
        d = rand_word();
        iv[0] = 1'b1; id[0] = d; ii[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ctrl ready/valid/busy got %b/%b/%b want 1/0/0", ir[0], ov[0], bz[0]);
        end
        n_checks++;
        if (dout(0) !== 128'h0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", dout(0)); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov[0] !== 1'b0 || dout(0) !== 128'h0) begin
            n_fail++; $display("FAIL post_reset_idle got %b/%h want 0/0", ov[0], dout(0));
        end
        d = rand_word();
        run_word(0, d, 1'b1, r, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL post_reset_latency got %0d want 4", lat); end
        n_checks++;
        if (r !== ref_word(d, 1'b1, 16)) begin
            n_fail++; $display("FAIL post_reset_data got %h want %h", r, ref_word(d, 1'b1, 16));
        end
    endtask

    task automatic test_sweep();
        logic [127:0] d, r, e;
        int lat, ln;
        for (int k = 1; k < 4; k++) begin
            ln = lanes_of[k];
            for (int m = 0; m < 2; m++) begin
                for (int w = 0; w < 256 / ln; w++) begin
                    d = '0;
                    for (int b = 0; b < ln; b++) d[8*b +: 8] = 8'(w * ln + b);
                    run_word(k, d, 1'(m), r, lat);
                    e = ref_word(d, 1'(m), ln);
                    n_checks++;
                    if (lat !== grp[k]) begin
                        n_fail++; $display("FAIL sweep_latency unit %0d got %0d want %0d", k, lat, grp[k]);
                    end
                    for (int b = 0; b < ln; b++) begin
                        n_checks++;
                        if (r[8*b +: 8] !== e[8*b +: 8]) begin
                            n_fail++;
                            $display("FAIL sweep_byte unit %0d inv=%0d in %h got %h want %h",
                                     k, m, d[8*b +: 8], r[8*b +: 8], e[8*b +: 8]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        build_tables();
        rst_n = 1'b0;
        iv = '0; ii = '0; orr = '0;
        for (int k = 0; k < 4; k++) id[k] = '0;
        #23;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_vectors(1'b0, {8'h53, 8'h01, 8'h0F, 8'hF0, 8'hAA, 8'hFF, 8'h00},
                           {8'hED, 8'h7C, 8'h76, 8'h8C, 8'hAC, 8'h16, 8'h63});
        test_vectors(1'b1, {8'hFF, 8'h00, 8'h76, 8'h8C, 8'hAC, 8'h16, 8'h63},
                           {8'h7D, 8'h52, 8'h0F, 8'hF0, 8'hAA, 8'hFF, 8'h00});
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_mode_isolation();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_sub_unit.md
# sbox_sub_unit

Parametrised, multi-cycle AES byte-substitution unit: takes a LANES-byte word, applies the forward S-box (SubBytes) or inverse S-box (InvSubBytes) to every byte using NSUB substitution engines per cycle, and returns the substituted word over a valid/ready handshake. It sits in the round datapath between AddRoundKey and ShiftRows. It replaces the single-byte combinational S-box lookup with a time-multiplexed, area-scalable engine.

## Interface
- LANES, default 16: bytes per word; data width is 8*LANES.
- NSUB, default 4: substitution engines used per cycle; must divide LANES; legal range is 1..LANES.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  unit can accept a word this cycle.
- in_data  input  8*LANES  input word; byte i is bits [8i+7:8i].
- in_inv  input  1  0 selects the forward S-box, 1 selects the inverse S-box; sampled with in_data.
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  8*LANES  substituted word; byte i = S(in byte i), or S^-1(in byte i) when in_inv is 1.
- busy  output  1  high in SUB state.

## Operation
- Substitution is computed with one shared GF(2^8) inversion (polynomial 0x11B, inv(0)=0) wrapped by the forward affine transform (constant 0x63) or the inverse affine transform (constant 0x05) applied before inversion. No 256-entry tables are used.
- GROUPS = LANES/NSUB. A 2-state-bit FSM has states IDLE, SUB, and DONE. An index counter runs 0..GROUPS-1.
- IDLE: in_ready=1. On in_valid&&in_ready: capture in_data and in_inv into the source register, set idx=0, clear the result register, and go to SUB.
- SUB: each cycle, bytes idx*NSUB .. idx*NSUB+NSUB-1 of the source are substituted and written into the same byte positions of the result register. idx increments.
  - When idx==GROUPS-1, that group is written, idx returns to 0, and the FSM goes to DONE.
  - in_valid is ignored in SUB, and in_ready=0.
- DONE: out_valid=1. out_data is the result register, held stable until the handshake completes.
  - On out_ready=1 with no new input, go to IDLE.
  - in_ready = out_ready in DONE. If in_valid and out_ready are both high, the result is consumed and the new word is captured in the same edge; the FSM goes directly to SUB.
- The mode is latched per word. Changing in_inv while not accepting has no effect on a word in flight.
- Reset (any time, including mid-SUB or in DONE): state=IDLE, idx=0, source and result registers = 0, out_valid=0, busy=0, in_ready=1 once rst_n is released. A partially substituted word is discarded and never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0.
- Accept at edge E. out_valid rises after edge E+GROUPS, so it is visible GROUPS cycles after acceptance. Default latency is 4 cycles.
- Sustained throughput:
  - With out_ready held high: one word per GROUPS+1 cycles (default 5).
  - With back-to-back accept in DONE: one word per GROUPS+1 cycles. No idle cycle is inserted.
- NSUB=LANES gives GROUPS=1, i.e. 1-cycle latency.
- Output hold: out_valid and out_data remain constant across any number of cycles with out_ready=0.
- in_ready is combinational from state and out_ready only, with no path from in_valid. out_valid and out_data are registered.

## Test plan
- Forward, default parameters: in_data bytes {00,FF,AA,F0,0F,01,53,…}, in_inv=0 -> out_data bytes {63,16,AC,8C,76,7C,ED,…}. out_valid asserts exactly 4 cycles after accept; every byte is checked against a reference model.
- Inverse: in_inv=1, bytes {63,16,AC,8C,76,00,FF} -> {00,FF,AA,F0,0F,52,7D}. A forward then inverse round trip on 64 random words returns the original words.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 7 cycles: out_data stays stable and in_ready=0.
  - Then raise out_ready with in_valid high: the result is consumed and the next word is accepted on the same edge. The next out_valid follows 4 cycles later, giving 5-cycle spacing.
- Mode isolation: toggle in_inv every cycle while a word is in SUB -> the result matches the mode sampled at accept.
- Reset mid-operation: assert rst_n=0 asynchronously during SUB (idx=2) -> outputs go immediately to in_ready=1 state values, out_valid=0, out_data=0. After release, the next word completes correctly with no stale bytes.
- Parameter sweep: (LANES,NSUB) = (16,1), (16,16), (4,2), with 256-value exhaustive coverage of both S-boxes -> latencies of 16, 1, and 2 cycles respectively, and all bytes correct.
